wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_pkg.sv | 37 +++
 rtl/wb_unit_load_align.sv | 53 +++++
 rtl/wb_unit.sv | 122 ++++++++++++
 tb/tb_wb_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back unit: load format codes, FSM states and
// the alignment rule applied when a load is accepted.
package wb_pkg;

    localparam int MEM_FUNC_W = 4;

    typedef enum logic [MEM_FUNC_W-1:0] {
        BS = 4'd0,
        BU = 4'd1,
        HS = 4'd2,
        HU = 4'd3,
        WS = 4'd4,
        WU = 4'd5,
        WD = 4'd6,
        WL = 4'd7,
        WR = 4'd8
    } mem_func_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_e;

    // k is the byte offset zero-extended to 3 bits; unaligned partial-word
    // merges (WL/WR) and byte loads can never be misaligned.
    function automatic logic misaligned(input logic [MEM_FUNC_W-1:0] func,
                                        input logic [2:0]            k);
        case (func)
            HS, HU:  return k[0];
            WS, WU:  return |k[1:0];
            WD:      return |k;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_unit_load_align.sv
// Combinational load formatter: extracts, extends or merges memory bytes
// according to the load format code and byte offset (little-endian).
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [MEM_FUNC_W-1:0]        mem_func,
    input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
    input  logic [DATA_W-1:0]            rt_data,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] rot;
    int                k;

    always_comb begin
        k   = int'(addr_lo);
        // rot puts byte k in lane 0, so extracts and WR read from the bottom.
        rot = '0;
        for (int b = 0; b < NB; b++) begin
            rot[8*b +: 8] = mem_rdata[8*((b + k) % NB) +: 8];
        end

        data = mem_rdata;
        case (mem_func)
            BS: data = DATA_W'($signed(rot[7:0]));
            BU: data = DATA_W'(rot[7:0]);
            HS: data = DATA_W'($signed(rot[15:0]));
            HU: data = DATA_W'(rot[15:0]);
            WS: data = DATA_W'($signed(rot[31:0]));
            WU: data = DATA_W'(rot[31:0]);
            WD: data = mem_rdata;
            WL: begin
                for (int b = 0; b < NB; b++) begin
                    if (b >= NB - 1 - k) data[8*b +: 8] = mem_rdata[8*(b - (NB - 1 - k)) +: 8];
                    else                 data[8*b +: 8] = rt_data[8*b +: 8];
                end
            end
            WR: begin
                for (int b = 0; b < NB; b++) begin
                    if (b <= NB - 1 - k) data[8*b +: 8] = rot[8*b +: 8];
                    else                 data[8*b +: 8] = rt_data[8*b +: 8];
                end
            end
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: accepts ALU results or loads, waits for the memory
// response with a timeout, formats load data and drives the register-file port.
module wb_unit
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mem_to_reg,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic [DATA_W-1:0]            rt_data,
    input  logic [MEM_FUNC_W-1:0]        mem_func,
    input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
    input  logic [REG_W-1:0]             dest_reg,
    input  logic                         reg_write,
    input  logic                         mem_rvalid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         wb_valid,
    output logic                         wb_we,
    output logic [REG_W-1:0]             wb_reg,
    output logic [DATA_W-1:0]            wb_data,
    output logic                         err_misalign,
    output logic                         err_timeout
);

    localparam int AW    = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;

    logic [REG_W-1:0]        dest_p1;
    logic                    reg_write_p1;
    logic [MEM_FUNC_W-1:0]   func_p1;
    logic [AW-1:0]           addr_lo_p1;
    logic [DATA_W-1:0]       rt_p1;
    logic [DATA_W-1:0]       fmt_data;

    assign in_ready = (state != WAIT_MEM);
    assign accept   = in_valid && in_ready;

    // Accept stage: instruction fields held for the load response.
    always_ff @(posedge clk) begin
        if (accept) begin
            dest_p1      <= dest_reg;
            reg_write_p1 <= reg_write;
            func_p1      <= mem_func;
            addr_lo_p1   <= addr_lo;
            rt_p1        <= rt_data;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .mem_func  (func_p1),
        .addr_lo   (addr_lo_p1),
        .rt_data   (rt_p1),
        .mem_rdata (mem_rdata),
        .data      (fmt_data)
    );

    // Write-back stage: FSM with registered register-file port and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    if (!accept) begin
                        state <= IDLE;
                    end else if (!mem_to_reg) begin
                        state    <= WRITE;
                        wb_valid <= 1'b1;
                        wb_we    <= reg_write;
                        wb_reg   <= dest_reg;
                        wb_data  <= alu_data;
                    end else if (misaligned(mem_func, 3'(addr_lo))) begin
                        state        <= IDLE;
                        err_misalign <= 1'b1;
                    end else begin
                        state <= WAIT_MEM;
                        cnt   <= '0;
                    end
                end
                WAIT_MEM: begin
                    // A response on the final allowed cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        state    <= WRITE;
                        wb_valid <= 1'b1;
                        wb_we    <= reg_write_p1;
                        wb_reg   <= dest_p1;
                        wb_data  <= fmt_data;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: table of load formats, directed corner
// sequences and randomized transactions against a byte-level reference model.
module tb_wb_unit;
    import wb_pkg::*;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 15;
    localparam int NB      = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              mem_to_reg;
    logic [31:0]       alu_data;
    logic [31:0]       rt_data;
    logic [3:0]        mem_func;
    logic [1:0]        addr_lo;
    logic [4:0]        dest_reg;
    logic              reg_write;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic              wb_we;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              err_misalign;
    logic              err_timeout;

    always #5 clk = ~clk;

    wb_unit #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_to_reg   (mem_to_reg),
        .alu_data     (alu_data),
        .rt_data      (rt_data),
        .mem_func     (mem_func),
        .addr_lo      (addr_lo),
        .dest_reg     (dest_reg),
        .reg_write    (reg_write),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_reg  = '0;

    typedef struct {
        logic [3:0]  f;
        int          k;
        logic [31:0] mem;
        logic [31:0] rt;
        logic [31:0] exp;
        bit          mis;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference formatter built from per-byte arrays.
    function automatic logic [31:0] fmt_ref(input logic [3:0] f, input int k,
                                            input logic [31:0] mem, input logic [31:0] rt);
        logic [7:0] m[4];
        logic [7:0] o[4];
        for (int i = 0; i < NB; i++) begin
            m[i] = mem[8*i +: 8];
            o[i] = rt[8*i +: 8];
        end
        case (f)
            BS:         return {{24{m[k][7]}}, m[k]};
            BU:         return {24'h0, m[k]};
            HS:         return {{16{m[k+1][7]}}, m[k+1], m[k]};
            HU:         return {16'h0, m[k+1], m[k]};
            WS, WU, WD: return mem;
            WL: begin
                for (int i = 0; i <= k; i++) o[NB-1-k+i] = m[i];
                return {o[3], o[2], o[1], o[0]};
            end
            WR: begin
                for (int i = k; i < NB; i++) o[i-k] = m[i];
                return {o[3], o[2], o[1], o[0]};
            end
            default:    return mem;
        endcase
    endfunction

    function automatic bit mis_ref(input logic [3:0] f, input int k);
        case (f)
            HS, HU:  return (k % 2) != 0;
            WS, WU:  return (k % 4) != 0;
            WD:      return k != 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic expect_write(input string tag, input logic [31:0] data,
                                input logic [4:0] dest, input bit rw);
        chk({tag, "_wb_valid"}, wb_valid, 1);
        chk({tag, "_wb_we"}, wb_we, rw);
        chk({tag, "_wb_reg"}, wb_reg, dest);
        chk({tag, "_wb_data"}, wb_data, data);
        chk({tag, "_no_err"}, {err_misalign, err_timeout}, 0);
        last_data = data;
        last_reg  = dest;
    endtask

    task automatic idle(input string tag, input int n);
        in_valid = 1'b0;
        repeat (n) begin
            tick();
            chk({tag, "_idle_valid"}, wb_valid, 0);
            chk({tag, "_idle_hold_data"}, wb_data, last_data);
            chk({tag, "_idle_hold_reg"}, wb_reg, last_reg);
            chk({tag, "_idle_ready"}, in_ready, 1);
        end
    endtask

    // One instruction; lat = WAIT_MEM cycle (1-based) carrying mem_rvalid, 0 = never.
    task automatic run_txn(input string tag, input bit is_load, input logic [3:0] f,
                           input int k, input logic [31:0] alu, input logic [31:0] rt,
                           input logic [31:0] mem, input logic [4:0] dest, input bit rw,
                           input int lat, input logic [31:0] exp_data, input bit exp_mis);
        bit done;
        in_valid   = 1'b1;
        mem_to_reg = is_load;
        mem_func   = f;
        addr_lo    = 2'(k);
        alu_data   = alu;
        rt_data    = rt;
        dest_reg   = dest;
        reg_write  = rw;
        mem_rvalid = 1'b0;
        tick();
        in_valid   = 1'b0;
        alu_data   = $urandom;
        rt_data    = $urandom;
        dest_reg   = 5'($urandom);
        reg_write  = 1'($urandom);
        mem_func   = 4'($urandom);
        addr_lo    = 2'($urandom);
        mem_to_reg = 1'($urandom);
        if (!is_load) begin
            expect_write({tag, "_alu"}, exp_data, dest, rw);
        end else if (exp_mis) begin
            chk({tag, "_misalign"}, err_misalign, 1);
            chk({tag, "_mis_no_valid"}, wb_valid, 0);
            chk({tag, "_mis_ready"}, in_ready, 1);
            chk({tag, "_mis_hold"}, wb_data, last_data);
        end else begin
            done = 1'b0;
            for (int c = 1; c <= TIMEOUT && !done; c++) begin
                chk({tag, "_wait_ready"}, in_ready, 0);
                chk({tag, "_wait_valid"}, wb_valid, 0);
                chk({tag, "_wait_tmo"}, err_timeout, 0);
                in_valid  = 1'($urandom);
                mem_rdata = $urandom;
                if (c == lat) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem;
                end
                tick();
                mem_rvalid = 1'b0;
                in_valid   = 1'b0;
                if (c == lat) begin
                    expect_write({tag, "_load"}, exp_data, dest, rw);
                    done = 1'b1;
                end else if (c == TIMEOUT) begin
                    chk({tag, "_timeout"}, err_timeout, 1);
                    chk({tag, "_tmo_no_valid"}, wb_valid, 0);
                    chk({tag, "_tmo_ready"}, in_ready, 1);
                    chk({tag, "_tmo_hold"}, wb_data, last_data);
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = '{BS, 2, 32'h0080FF00, 32'h0, 32'hFFFFFF80, 0};
        tbl[1]  = '{BU, 2, 32'h0080FF00, 32'h0, 32'h00000080, 0};
        tbl[2]  = '{BS, 1, 32'h0080FF00, 32'h0, 32'hFFFFFFFF, 0};
        tbl[3]  = '{BU, 0, 32'h0080FF00, 32'h0, 32'h00000000, 0};
        tbl[4]  = '{HS, 2, 32'h80010000, 32'h0, 32'hFFFF8001, 0};
        tbl[5]  = '{HU, 2, 32'h80010000, 32'h0, 32'h00008001, 0};
        tbl[6]  = '{HS, 0, 32'h00007FFF, 32'h0, 32'h00007FFF, 0};
        tbl[7]  = '{WS, 0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 0};
        tbl[8]  = '{WD, 0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 0};
        tbl[9]  = '{WL, 1, 32'hAABBCCDD, 32'h11223344, 32'hCCDD3344, 0};
        tbl[10] = '{WR, 2, 32'hAABBCCDD, 32'h11223344, 32'h1122AABB, 0};
        tbl[11] = '{WL, 0, 32'hAABBCCDD, 32'h11223344, 32'hDD223344, 0};
        tbl[12] = '{WL, 3, 32'hAABBCCDD, 32'h11223344, 32'hAABBCCDD, 0};
        tbl[13] = '{WR, 0, 32'hAABBCCDD, 32'h11223344, 32'hAABBCCDD, 0};
        tbl[14] = '{WR, 3, 32'hAABBCCDD, 32'h11223344, 32'h112233AA, 0};
        tbl[15] = '{4'd12, 1, 32'hCAFEF00D, 32'h11223344, 32'hCAFEF00D, 0};
        tbl[16] = '{HU, 1, 32'h12345678, 32'h0, 32'h0, 1};
        tbl[17] = '{WD, 2, 32'h12345678, 32'h0, 32'h0, 1};
        tbl[18] = '{WS, 2, 32'h12345678, 32'h0, 32'h0, 1};
        tbl[19] = '{HS, 3, 32'h12345678, 32'h0, 32'h0, 1};

        rst = 1'b1; in_valid = 1'b0; mem_to_reg = 1'b0; alu_data = '0; rt_data = '0;
        mem_func = '0; addr_lo = '0; dest_reg = '0; reg_write = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_reg", wb_reg, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_errs", {err_misalign, err_timeout}, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;
        idle("post_rst", 1);

        run_txn("alu_basic", 0, BS, 0, 32'h12345678, 0, 0, 5'd7, 1, 0, 32'h12345678, 0);
        idle("alu_basic", 1);

        run_txn("bs_lat3", 1, BS, 2, 0, 0, 32'h0080FF00, 5'd3, 1, 3, 32'hFFFFFF80, 0);
        idle("bs_lat3", 1);

        for (int i = 0; i < 20; i++) begin
            run_txn($sformatf("tbl%0d", i), 1, tbl[i].f, tbl[i].k, 0, tbl[i].rt,
                    tbl[i].mem, 5'(i), 1'(i % 2), 1, tbl[i].exp, tbl[i].mis);
            idle($sformatf("tbl%0d", i), 1);
        end

        run_txn("hu_mis", 1, HU, 1, 0, 0, 32'h12345678, 5'd9, 1, 1, 0, 1);
        run_txn("after_mis", 0, BS, 0, 32'h0BADCAFE, 0, 0, 5'd10, 1, 0, 32'h0BADCAFE, 0);
        idle("after_mis", 1);

        run_txn("b2b_a", 0, BS, 0, 32'h00000001, 0, 0, 5'd1, 1, 0, 32'h00000001, 0);
        run_txn("b2b_b", 0, BS, 0, 32'h00000002, 0, 0, 5'd2, 0, 0, 32'h00000002, 0);
        run_txn("b2b_c", 0, BS, 0, 32'h00000003, 0, 0, 5'd3, 1, 0, 32'h00000003, 0);
        run_txn("b2b_ld", 1, BU, 3, 0, 0, 32'h7F000000, 5'd4, 1, 1, 32'h0000007F, 0);
        idle("b2b", 1);

        run_txn("tmo", 1, WD, 0, 0, 0, 32'h55555555, 5'd11, 1, 0, 0, 0);
        idle("tmo", 1);
        run_txn("tmo_edge", 1, WD, 0, 0, 0, 32'h66666666, 5'd12, 1, TIMEOUT, 32'h66666666, 0);
        idle("tmo_edge", 1);

        in_valid = 1'b1; mem_to_reg = 1'b1; mem_func = BU; addr_lo = 2'd0; dest_reg = 5'd13; reg_write = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_wait_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wait_ready_after", in_ready, 1);
        chk("rst_wait_valid", wb_valid, 0);
        chk("rst_wait_errs", {err_misalign, err_timeout}, 0);
        chk("rst_wait_data", wb_data, 0);
        last_data = '0;
        last_reg  = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        chk("rst_wait_ignored_rvalid", wb_valid, 0);
        tick();
        chk("idle_ignored_rvalid", wb_valid, 0);
        mem_rvalid = 1'b0;
        idle("rst_wait", 1);

        for (int n = 0; n < 40; n++) begin
            bit          ld;
            logic [3:0]  f;
            int          k;
            int          lat;
            int          sel;
            logic [31:0] alu;
            logic [31:0] rt;
            logic [31:0] mem;
            logic [4:0]  dest;
            bit          rw;
            logic [31:0] exp;
            ld   = ($urandom % 3) != 0;
            f    = 4'($urandom_range(0, 10));
            k    = int'($urandom % 4);
            alu  = $urandom;
            rt   = $urandom;
            mem  = $urandom;
            dest = 5'($urandom);
            rw   = 1'($urandom);
            sel  = int'($urandom % 8);
            lat  = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : int'($urandom_range(1, 4));
            exp  = ld ? fmt_ref(f, k, mem, rt) : alu;
            run_txn($sformatf("rnd%0d", n), ld, f, k, alu, rt, mem, dest, rw, lat, exp,
                    ld && mis_ref(f, k));
            if ($urandom % 2) idle($sformatf("rnd%0d", n), 1);
        end
        idle("end", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
